// File: rtl/dac_multitone_mixer.sv
// rtl/dac_multitone_mixer.sv - multitone NCO sum, saturate and offset-binary DAC drive
//
// Purpose: holds a shadow/active phase-increment bank for NUM_CH NCOs and
// mixes their signed samples into one saturated offset-binary DAC code.
// Ports:
//   clk, reset           sample clock, async active-high reset
//   cfg_wr/addr/wdata    shadow writes (addr < NUM_CH), commit (addr 15)
//   phi_inc_o            active increments, channel k at [k*PHASE_W +: PHASE_W]
//   smp_i, smp_valid_i   signed samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   ch_en                per-channel enable into the sum
//   dac_o, dac_valid_o   offset-binary code and its update strobe
//   clip_o, clip_cnt_o   sticky clip flag and saturating clip count
//   clip_clr             clears clip_o and clip_cnt_o
module dac_multitone_mixer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 14,
  parameter int PHASE_W  = 32,
  parameter int DAC_W    = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_wr,
  input  logic [3:0]                   cfg_addr,
  input  logic [PHASE_W-1:0]           cfg_wdata,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [NUM_CH*PHASE_W-1:0]    phi_inc_o,
  input  logic [NUM_CH*SAMPLE_W-1:0]   smp_i,
  input  logic                         smp_valid_i,
  output logic [DAC_W-1:0]             dac_o,
  output logic                         dac_valid_o,
  output logic                         clip_o,
  input  logic                         clip_clr,
  output logic [15:0]                  clip_cnt_o
);

  // Sum width large enough that NUM_CH full-scale samples never overflow.
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  // Comparison width covering both the sum and the DAC range.
  localparam int EXT_W = (SUM_W > DAC_W) ? SUM_W : DAC_W;

  localparam logic signed [EXT_W-1:0] MAX_V =
    {{(EXT_W-DAC_W+1){1'b0}}, {(DAC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V =
    {{(EXT_W-DAC_W+1){1'b1}}, {(DAC_W-1){1'b0}}};
  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};

  // Increment bank
  logic [NUM_CH-1:0][PHASE_W-1:0] shadow_q;
  logic [NUM_CH-1:0][PHASE_W-1:0] active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else if (cfg_wr) begin
      if (cfg_addr == 4'hF) begin
        active_q <= shadow_q;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (cfg_addr == 4'(k)) shadow_q[k] <= cfg_wdata;
        end
      end
    end
  end

  assign phi_inc_o = active_q;

  // S1: masked sample capture
  logic [NUM_CH-1:0][SAMPLE_W-1:0] s1_smp_q;
  logic                            s1_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_smp_q <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= smp_valid_i;
      if (smp_valid_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          s1_smp_q[k] <= ch_en[k] ? smp_i[k*SAMPLE_W +: SAMPLE_W] : '0;
        end
      end
    end
  end

  // S2: full-precision signed sum
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;
  logic                    s2_vld_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_d = sum_d + SUM_W'($signed(s1_smp_q[k]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q    <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) sum_q <= sum_d;
    end
  end

  // S3: saturate, convert to offset binary, count clips
  logic signed [EXT_W-1:0] sum_ext;
  logic                    over_hi;
  logic                    over_lo;
  logic                    clip_evt;
  logic [DAC_W-1:0]        sat_d;
  logic [DAC_W-1:0]        dac_d;
  logic [15:0]             clip_cnt_d;
  logic [DAC_W-1:0]        dac_q;
  logic                    dac_valid_q;
  logic                    clip_q;
  logic [15:0]             clip_cnt_q;

  always_comb begin
    sum_ext  = EXT_W'(sum_q);
    over_hi  = sum_ext > MAX_V;
    over_lo  = sum_ext < MIN_V;
    clip_evt = s2_vld_q && (over_hi || over_lo);
    if (over_hi)      sat_d = {1'b0, {(DAC_W-1){1'b1}}};
    else if (over_lo) sat_d = {1'b1, {(DAC_W-1){1'b0}}};
    else              sat_d = sum_ext[DAC_W-1:0];
    // Flipping the sign bit maps two's complement onto offset binary.
    dac_d = {~sat_d[DAC_W-1], sat_d[DAC_W-2:0]};
    // A clip coinciding with a clear restarts the count at one.
    if (clip_clr)                  clip_cnt_d = 16'd1;
    else if (clip_cnt_q == 16'hFFFF) clip_cnt_d = clip_cnt_q;
    else                           clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_q       <= MIDSCALE;
      dac_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      clip_cnt_q  <= '0;
    end else begin
      dac_valid_q <= s2_vld_q;
      if (s2_vld_q) dac_q <= dac_d;
      if (clip_evt) begin
        clip_q     <= 1'b1;
        clip_cnt_q <= clip_cnt_d;
      end else if (clip_clr) begin
        clip_q     <= 1'b0;
        clip_cnt_q <= '0;
      end
    end
  end

  assign dac_o       = dac_q;
  assign dac_valid_o = dac_valid_q;
  assign clip_o      = clip_q;
  assign clip_cnt_o  = clip_cnt_q;

endmodule

// File: tb/tb_dac_multitone_mixer.sv
// tb/tb_dac_multitone_mixer.sv - self-checking bench for dac_multitone_mixer
module tb_dac_multitone_mixer;

  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_wr = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [31:0]  cfg_wdata = '0;
  logic [3:0]   ch_en = '0;
  logic [127:0] phi_inc_o;
  logic [55:0]  smp_i = '0;
  logic         smp_valid_i = 1'b0;
  logic [13:0]  dac_o;
  logic         dac_valid_o;
  logic         clip_o;
  logic         clip_clr = 1'b0;
  logic [15:0]  clip_cnt_o;

  dac_multitone_mixer dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .ch_en(ch_en), .phi_inc_o(phi_inc_o),
    .smp_i(smp_i), .smp_valid_i(smp_valid_i), .dac_o(dac_o),
    .dac_valid_o(dac_valid_o), .clip_o(clip_o), .clip_clr(clip_clr),
    .clip_cnt_o(clip_cnt_o)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: outputs at an edge come from the inputs seen two edges earlier.
  int          q_vld[$];
  int          q_sum[$];
  int          m_vld = 0;
  int          m_dac = 8192;
  int          m_clip = 0;
  int          m_cnt = 0;
  logic [31:0] m_shadow[NCH];
  logic [31:0] m_active[NCH];

  initial begin
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
  end

  function automatic int smp_of(input int k);
    logic [13:0] raw;
    raw = smp_i[k*14 +: 14];
    return int'($signed(raw));
  endfunction

  function automatic logic [127:0] active_flat();
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < NCH; k++) p[k*32 +: 32] = m_active[k];
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    int s;
    int v;
    int sm;
    int evt;
    if (reset) begin
      q_vld.delete();
      q_sum.delete();
      m_vld = 0; m_dac = 8192; m_clip = 0; m_cnt = 0;
      for (int k = 0; k < NCH; k++) begin
        m_shadow[k] = '0;
        m_active[k] = '0;
      end
    end else begin
      s = 0;
      for (int k = 0; k < NCH; k++) if (ch_en[k]) s += smp_of(k);
      q_vld.push_back(int'(smp_valid_i));
      q_sum.push_back(s);
      v = 0; sm = 0;
      if (q_vld.size() > 2) begin
        v = q_vld.pop_front();
        sm = q_sum.pop_front();
      end
      m_vld = v;
      evt = 0;
      if (v != 0) begin
        if (sm > 8191) begin m_dac = 16383; evt = 1; end
        else if (sm < -8192) begin m_dac = 0; evt = 1; end
        else m_dac = sm + 8192;
      end
      if (evt != 0) begin
        m_clip = 1;
        if (clip_clr) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt++;
      end else if (clip_clr) begin
        m_clip = 0; m_cnt = 0;
      end
      if (cfg_wr) begin
        if (cfg_addr == 4'hF) begin
          for (int k = 0; k < NCH; k++) m_active[k] = m_shadow[k];
        end else if (int'(cfg_addr) < NCH) begin
          m_shadow[cfg_addr] = cfg_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("dac_valid_model", dac_valid_o, m_vld);
    check("dac_model", dac_o, m_dac);
    check("clip_model", clip_o, m_clip);
    check("clip_cnt_model", clip_cnt_o, m_cnt);
    check("phi_model", phi_inc_o, active_flat());
  end

  function automatic logic [55:0] pk(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // One valid sample; returns at the negedge where its result is visible.
  task automatic pulse(input int a, input int b, input int c, input int d,
                       input logic [3:0] en, input logic clr);
    @(negedge clk);
    smp_i = pk(a, b, c, d); ch_en = en; smp_valid_i = 1'b1;
    @(negedge clk);
    smp_valid_i = 1'b0;
    @(negedge clk);
    clip_clr = clr;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  function automatic int rnd_smp();
    case ($urandom % 4)
      0: return 8191;
      1: return -8192;
      default: return int'($urandom_range(0, 16383)) - 8192;
    endcase
  endfunction

  logic [3:0] vpat;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dac", dac_o, 14'h2000);
    check("reset_valid", dac_valid_o, 1'b0);
    check("reset_clip", clip_o, 1'b0);
    check("reset_cnt", clip_cnt_o, 16'h0);
    check("reset_phi", phi_inc_o, 128'h0);
    reset = 1'b0;

    // Shadow / commit
    cfg(4'd0, 32'h0CCCCCCD);
    cfg(4'd1, 32'h40000000);
    check("phi_before_commit", phi_inc_o, 128'h0);
    cfg(4'hF, 32'h0);
    check("phi_ch0_commit", phi_inc_o[31:0], 32'h0CCCCCCD);
    check("phi_ch1_commit", phi_inc_o[63:32], 32'h40000000);
    check("phi_ch23_commit", phi_inc_o[127:64], 64'h0);
    cfg(4'd9, 32'hDEADBEEF);
    cfg(4'hF, 32'h0);
    check("phi_after_addr9", phi_inc_o, {64'h0, 32'h40000000, 32'h0CCCCCCD});

    // Normal sum
    pulse(100, -40, 0, 0, 4'hF, 1'b0);
    check("sum_valid", dac_valid_o, 1'b1);
    check("sum_dac", dac_o, 14'h203C);
    check("sum_noclip", clip_o, 1'b0);
    @(negedge clk);
    check("sum_single_pulse", dac_valid_o, 1'b0);

    // Saturation
    pulse(8191, 8191, 8191, 8191, 4'hF, 1'b0);
    check("sat_hi_dac", dac_o, 14'h3FFF);
    check("sat_hi_clip", clip_o, 1'b1);
    check("sat_hi_cnt", clip_cnt_o, 16'd1);
    pulse(-8192, -8192, -8192, -8192, 4'hF, 1'b0);
    check("sat_lo_dac", dac_o, 14'h0000);
    check("sat_lo_cnt", clip_cnt_o, 16'd2);
    pulse(8191, 8191, 8191, 8191, 4'hF, 1'b1);
    check("clr_with_clip_cnt", clip_cnt_o, 16'd1);
    check("clr_with_clip_flag", clip_o, 1'b1);

    // Enable masking
    pulse(5, 8191, 8191, 8191, 4'b0001, 1'b0);
    check("mask_dac", dac_o, 14'h2005);
    check("mask_cnt", clip_cnt_o, 16'd1);

    // Valid gaps: 1,0,1,1
    ch_en = 4'hF;
    @(negedge clk); smp_i = pk(10, 0, 0, 0); smp_valid_i = 1'b1;
    @(negedge clk); smp_valid_i = 1'b0;
    @(negedge clk); smp_i = pk(20, 0, 0, 0); smp_valid_i = 1'b1;
    @(negedge clk);
    vpat[3] = dac_valid_o;
    check("gap_first_dac", dac_o, 14'h200A);
    smp_i = pk(30, 0, 0, 0);
    @(negedge clk);
    vpat[2] = dac_valid_o;
    check("gap_hold_dac", dac_o, 14'h200A);
    smp_valid_i = 1'b0;
    @(negedge clk); vpat[1] = dac_valid_o;
    @(negedge clk); vpat[0] = dac_valid_o;
    check("gap_valid_pattern", vpat, 4'b1011);
    check("gap_last_dac", dac_o, 14'h201E);

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      smp_valid_i = ($urandom % 4) != 0;
      ch_en = 4'($urandom);
      smp_i = pk(rnd_smp(), rnd_smp(), rnd_smp(), rnd_smp());
      clip_clr = ($urandom % 16) == 0;
      cfg_wr = ($urandom % 8) == 0;
      cfg_addr = 4'($urandom);
      cfg_wdata = $urandom;
    end
    @(negedge clk);
    clip_clr = 1'b0; cfg_wr = 1'b0;

    // Reset mid-stream with samples in flight
    cfg(4'd2, 32'h12345678);
    cfg(4'hF, 32'h0);
    check("pre_reset_phi_ch2", phi_inc_o[95:64], 32'h12345678);
    ch_en = 4'hF;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      smp_i = pk(1000 + n, 0, 0, 0); smp_valid_i = 1'b1;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    smp_valid_i = 1'b0;
    check("rst_mid_dac", dac_o, 14'h2000);
    check("rst_mid_valid", dac_valid_o, 1'b0);
    check("rst_mid_phi", phi_inc_o, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rst_no_stale_valid", dac_valid_o, 1'b0);
      check("rst_after_dac", dac_o, 14'h2000);
    end
    check("rst_after_phi", phi_inc_o, 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
